// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control path: FSM states, opcode/funct values,
// ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        BRANCH,
        JUMP
    } state_e;

    // What the ALU is being used for this cycle; the decoder resolves it to an op.
    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ADD,
        CLS_SUB,
        CLS_RTYPE,
        CLS_ITYPE
    } alu_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    function automatic logic rtype_supported(input logic [5:0] funct);
        return (funct == F_ADD) || (funct == F_ADDU) || (funct == F_SUB) ||
               (funct == F_AND) || (funct == F_OR)   || (funct == F_SLT);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU usage class of the current cycle plus opcode/funct to an ALU op.
// Shared with the single-cycle decoder.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_class_e  alu_class,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_op
);

    always_comb begin
        alu_op = ALU_AND;
        case (alu_class)
            CLS_ADD: alu_op = ALU_ADD;
            CLS_SUB: alu_op = ALU_SUB;
            CLS_RTYPE: begin
                case (funct)
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_SLT:   alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            CLS_ITYPE: begin
                case (opcode)
                    OP_LUI:  alu_op = ALU_LUI;
                    OP_ORI:  alu_op = ALU_OR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: one state register, outputs decoded from the state
// with the few handshake/zero-flag dependent terms added combinationally.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal
);

    state_e     state_q, state_d;
    alu_class_e alu_class;

    alu_decoder u_alu_decoder (
        .alu_class (alu_class),
        .opcode    (opcode),
        .funct     (funct),
        .alu_op    (alu_op)
    );

    // Reset forces IDLE, whose decode is all-zero, so outputs clear asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_class  = CLS_NONE;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;

            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_class = CLS_ADD;
                pc_src    = PC_SRC_ALU;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end

            // Branch target is computed here so BRANCH can use the ALU for the compare.
            DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                alu_class = CLS_ADD;
                case (opcode)
                    OP_LW, OP_SW:              state_d = MEM_ADDR;
                    OP_LUI, OP_ORI, OP_ADDIU:  state_d = EXEC_I;
                    OP_BEQ, OP_BNE:            state_d = BRANCH;
                    OP_J:                      state_d = JUMP;
                    OP_RTYPE: begin
                        if (rtype_supported(funct)) begin
                            state_d = EXEC_R;
                        end else begin
                            illegal = 1'b1;
                            state_d = FETCH;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end

            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_class = CLS_ADD;
                state_d   = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end

            MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = MEM_WB;
            end

            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end

            MEM_WRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end

            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_class = CLS_RTYPE;
                state_d   = ALU_WB;
            end

            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_class = CLS_ITYPE;
                state_d   = ALU_WB;
            end

            ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (opcode == OP_RTYPE);
                retire    = 1'b1;
                state_d   = FETCH;
            end

            BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_class = CLS_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = (opcode == OP_BNE) ? ~zero : zero;
                retire    = 1'b1;
                state_d   = FETCH;
            end

            JUMP: begin
                pc_src   = PC_SRC_JUMP;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the MIPS datapath: it splits each instruction into fetch, decode, execute, memory and writeback cycles over a single shared ALU and one unified instruction/data memory. It sits beside the register file, ALU and memory port and drives every datapath mux, write enable and memory request. It supports the same instruction subset as the single-cycle decoder. Memory accesses use a request/ready handshake, so the controller stalls for any number of wait cycles.

## Interface
Parameters:
- none; all encodings come from `mips_ctrl_pkg`.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag, combinational from the current ALU inputs
- mem_ready  in  1  memory completes the request this cycle
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a write; valid only while mem_req=1
- iord  out  1  memory address source: 0=PC, 1=ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- alu_src_a  out  1  ALU A operand: 0=PC, 1=reg A
- alu_src_b  out  2  ALU B operand: 00=reg B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
- alu_op  out  3  ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_LUI=011, ALU_SUB=110, ALU_SLT=111
- reg_dst  out  1  register write address: 0=rt, 1=rd
- mem_to_reg  out  1  register write data: 0=ALUOut, 1=memory data register
- reg_write  out  1  register file write enable
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode/funct

## Operation
- FSM states: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP.
- IDLE: the reset state. All outputs are 0. The FSM moves to FETCH on the first clock after reset is released.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
  - The FSM holds in FETCH while mem_ready=0.
  - On the mem_ready=1 cycle: ir_write=1 and pc_write=1, then go to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=ADD. This precomputes the branch target into ALUOut.
  - Next state by opcode:
    - LW (100011), SW (101011) → MEM_ADDR
    - R-type (000000) with funct ADD/ADDU/SUB/AND/OR/SLT → EXEC_R
    - LUI (001111), ORI (001101), ADDIU (001001) → EXEC_I
    - BEQ (000100), BNE (000101) → BRANCH
    - J (000010) → JUMP
    - anything else: illegal=1, return to FETCH, no retire
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state is MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_req=1, iord=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, retire=1. Next state is FETCH.
- MEM_WRITE: mem_req=1, mem_write=1, iord=1. Hold until mem_ready; on that cycle retire=1, then go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00. alu_op by funct:
  - ADD, ADDU → ADD
  - SUB → SUB
  - AND → AND
  - OR → OR
  - SLT → SLT
- EXEC_I: alu_src_a=1, alu_src_b=10. alu_op: LUI → LUI, ORI → OR, ADDIU → ADD.
- ALU_WB: reg_write=1, mem_to_reg=0, retire=1, then FETCH.
  - reg_dst=1 for R-type, 0 for I-type.
  - The opcode is taken from the instruction register, which is stable from DECODE until the next FETCH completes.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01.
  - pc_write = zero for BEQ, ~zero for BNE.
  - retire=1, then FETCH.
- JUMP: pc_src=10, pc_write=1, retire=1, then FETCH.

## Timing
- Outputs are Moore decodes of the state, except:
  - pc_write and ir_write in FETCH, retire in MEM_WRITE, and the exit from the memory states depend on mem_ready;
  - pc_write in BRANCH depends on zero.
- Cycles per instruction with zero-wait memory:
  - branch, jump: 3
  - R-type, I-type ALU, SW: 4
  - LW: 5
  - Each memory wait cycle adds one.
- Handshake:
  - Once raised, mem_req stays high, with iord and mem_write stable, until the cycle mem_ready=1 is sampled.
  - mem_req drops in the cycle after that.
  - mem_ready while mem_req=0 is ignored.
- Reset asserted mid-operation: all outputs go to 0 immediately and asynchronously, including a pending mem_req. The state goes to IDLE. No retire is issued for the interrupted instruction.
- At most one of retire and illegal is asserted per instruction. Neither is ever asserted in IDLE or FETCH.

## Structure
- `mips_ctrl_pkg` holds:
  - the state enum;
  - the opcode and funct localparams;
  - the alu_op, alu_src_b and pc_src encodings.
- One combinational sub-module, `alu_decoder`: (state class, opcode, funct) → alu_op. It is reused by the single-cycle path.
- The FSM and output decode live in `multicycle_controller`.

## Test plan
- Zero-wait R-type ADD (opcode 000000, funct 100000): states FETCH, DECODE, EXEC_R, ALU_WB; reg_dst=1, reg_write=1 in cycle 4; retire high for exactly 1 cycle.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM_READ: mem_req held high for 4 cycles each time, iord=1 only in MEM_READ; retire occurs at cycle 11.
- BEQ with zero=1 gives pc_write=1, pc_src=01. BNE with zero=1 gives pc_write=0. Both take 3 cycles.
- Unsupported opcode 111111: illegal pulses in DECODE, no reg_write/mem_req/retire, next state FETCH.
- rst_n asserted during MEM_WRITE with mem_req=1: mem_req=0 in the same cycle; after release, IDLE for 1 cycle, then FETCH with mem_req=1.
